// File: rtl/menu_cursor.sv
// Menu cursor: edge-detected left/right/select buttons move a committed slot
// index and animate the cursor x toward that slot; selections wait for an ack.
module menu_cursor #(
    parameter int unsigned               N_ITEMS  = 4,
    parameter logic [N_ITEMS*16-1:0]     POS_X    = {16'd490, 16'd335, 16'd205, 16'd65},
    parameter int unsigned               MY       = 430,
    parameter int unsigned               R        = 10,
    parameter int unsigned               STEP     = 4,
    parameter int unsigned               TICK_DIV = 1,
    parameter int unsigned               WRAP     = 1,
    localparam int unsigned              IW       = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_enable,
    input  logic          i_left,
    input  logic          i_right,
    input  logic          i_select,
    input  logic          i_sel_ack,
    output logic [15:0]   o_cx,
    output logic [15:0]   o_cy,
    output logic [15:0]   o_cr,
    output logic [IW-1:0] o_index,
    output logic          o_moving,
    output logic          o_sel_valid,
    output logic [IW-1:0] o_sel_index
);

    localparam int unsigned   TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N_ITEMS - 1);
    localparam logic [15:0]   STEP16    = 16'(STEP);
    localparam logic [15:0]   CX_RST    = POS_X[15:0];

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        SELECT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] index_q, index_d;
    logic [15:0]   cx_q, cx_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          sel_valid_q, sel_valid_d;
    logic [IW-1:0] sel_index_q, sel_index_d;
    logic          left_dly_q, right_dly_q, select_dly_q;

    logic          left_cmd, right_cmd, sel_cmd;
    logic [15:0]   target;
    logic [15:0]   cx_step;

    assign left_cmd  = i_left   & ~left_dly_q;
    assign right_cmd = i_right  & ~right_dly_q;
    assign sel_cmd   = i_select & ~select_dly_q;

    always_comb begin
        target = CX_RST;
        for (int unsigned k = 0; k < N_ITEMS; k++) begin
            if (index_q == IW'(k)) begin
                target = POS_X[k*16 +: 16];
            end
        end
    end

    // One animation step toward the target, clamped so it lands exactly on it.
    always_comb begin
        cx_step = cx_q;
        if (cx_q < target) begin
            cx_step = ((target - cx_q) <= STEP16) ? target : cx_q + STEP16;
        end else if (cx_q > target) begin
            cx_step = ((cx_q - target) <= STEP16) ? target : cx_q - STEP16;
        end
    end

    // State register (delay copies reset to 1 so a held button is not a command)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            index_q      <= '0;
            cx_q         <= CX_RST;
            tick_q       <= '0;
            sel_valid_q  <= 1'b0;
            sel_index_q  <= '0;
            left_dly_q   <= 1'b1;
            right_dly_q  <= 1'b1;
            select_dly_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            cx_q         <= cx_d;
            tick_q       <= tick_d;
            sel_valid_q  <= sel_valid_d;
            sel_index_q  <= sel_index_d;
            left_dly_q   <= i_left;
            right_dly_q  <= i_right;
            select_dly_q <= i_select;
        end
    end

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        cx_d        = cx_q;
        tick_d      = tick_q;
        sel_valid_d = sel_valid_q;
        sel_index_d = sel_index_q;
        case (state_q)
            IDLE: begin
                if (i_enable) begin
                    if (sel_cmd) begin
                        state_d     = SELECT;
                        sel_valid_d = 1'b1;
                        sel_index_d = index_q;
                    end else if (left_cmd && !right_cmd) begin
                        if (index_q != '0) begin
                            index_d = index_q - IW'(1);
                            state_d = MOVE;
                            tick_d  = '0;
                        end else if (WRAP != 0) begin
                            index_d = LAST_IDX;
                            state_d = MOVE;
                            tick_d  = '0;
                        end
                    end else if (right_cmd && !left_cmd) begin
                        if (index_q != LAST_IDX) begin
                            index_d = index_q + IW'(1);
                            state_d = MOVE;
                            tick_d  = '0;
                        end else if (WRAP != 0) begin
                            index_d = '0;
                            state_d = MOVE;
                            tick_d  = '0;
                        end
                    end
                end
            end
            MOVE: begin
                // Slots sharing an x-coordinate leave nothing to animate.
                if (cx_q == target) begin
                    state_d = IDLE;
                end else if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    cx_d   = cx_step;
                    if (cx_step == target) begin
                        state_d = IDLE;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            SELECT: begin
                if (i_sel_ack) begin
                    state_d     = IDLE;
                    sel_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_cx        = cx_q;
        o_cy        = 16'(MY);
        o_cr        = 16'(R);
        o_index     = index_q;
        o_moving    = (state_q == MOVE);
        o_sel_valid = sel_valid_q;
        o_sel_index = sel_index_q;
    end

endmodule

// File: tb/tb_menu_cursor.sv
// Directed bench for menu_cursor: default, non-wrapping and divided-tick instances
// share one stimulus stream; vectors and sequences carry hand-computed expectations.
module tb_menu_cursor;

    logic clk = 1'b0;
    logic rst_n, en, l, r, s, ack;

    logic [15:0] cx_a, cy_a, cr_a, cx_b, cy_b, cr_b, cx_c, cy_c, cr_c;
    logic [1:0]  idx_a, sidx_a, idx_b, sidx_b, idx_c, sidx_c;
    logic        mov_a, sv_a, mov_b, sv_b, mov_c, sv_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    menu_cursor dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_left(l), .i_right(r),
        .i_select(s), .i_sel_ack(ack), .o_cx(cx_a), .o_cy(cy_a), .o_cr(cr_a),
        .o_index(idx_a), .o_moving(mov_a), .o_sel_valid(sv_a), .o_sel_index(sidx_a)
    );

    menu_cursor #(.WRAP(0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_left(l), .i_right(r),
        .i_select(s), .i_sel_ack(ack), .o_cx(cx_b), .o_cy(cy_b), .o_cr(cr_b),
        .o_index(idx_b), .o_moving(mov_b), .o_sel_valid(sv_b), .o_sel_index(sidx_b)
    );

    menu_cursor #(.TICK_DIV(3), .STEP(4)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_left(l), .i_right(r),
        .i_select(s), .i_sel_ack(ack), .o_cx(cx_c), .o_cy(cy_c), .o_cr(cr_c),
        .o_index(idx_c), .o_moving(mov_c), .o_sel_valid(sv_c), .o_sel_index(sidx_c)
    );

    typedef struct {
        logic en, l, r, s, ack;
        int   idx, mov, sv, sidx, cx;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int exp_cx;
        bit found;

        rst_n = 1'b0; en = 1'b1; l = 1'b0; r = 1'b0; s = 1'b0; ack = 1'b0;
        #12;
        chk("rst_cx", cx_a, 65);
        chk("rst_idx", idx_a, 0);
        chk("rst_moving", mov_a, 0);
        chk("rst_sel_valid", sv_a, 0);
        chk("rst_sel_index", sidx_a, 0);
        chk("cy_const", cy_a, 430);
        chk("cr_const", cr_a, 10);
        @(negedge clk);
        rst_n = 1'b1;

        //            en l  r  s  ack  idx mov sv sidx cx
        vecs[0]  = '{1, 0, 0, 0, 0,   0,  0,  0, 0,  65};
        vecs[1]  = '{1, 1, 1, 0, 0,   0,  0,  0, 0,  65};
        vecs[2]  = '{1, 0, 0, 0, 0,   0,  0,  0, 0,  65};
        vecs[3]  = '{0, 0, 1, 0, 0,   0,  0,  0, 0,  65};
        vecs[4]  = '{1, 0, 0, 0, 0,   0,  0,  0, 0,  65};
        vecs[5]  = '{1, 0, 0, 1, 0,   0,  0,  1, 0,  65};
        vecs[6]  = '{1, 1, 0, 0, 0,   0,  0,  1, 0,  65};
        vecs[7]  = '{1, 0, 0, 0, 1,   0,  0,  0, 0,  65};
        vecs[8]  = '{1, 0, 0, 0, 1,   0,  0,  0, 0,  65};
        vecs[9]  = '{1, 0, 1, 1, 0,   0,  0,  1, 0,  65};
        vecs[10] = '{1, 0, 0, 0, 1,   0,  0,  0, 0,  65};
        vecs[11] = '{1, 1, 0, 0, 0,   3,  1,  0, 0,  65};

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            en = vecs[i].en; l = vecs[i].l; r = vecs[i].r; s = vecs[i].s; ack = vecs[i].ack;
            cyc();
            chk($sformatf("v%0d_idx", i), idx_a, vecs[i].idx);
            chk($sformatf("v%0d_moving", i), mov_a, vecs[i].mov);
            chk($sformatf("v%0d_sel_valid", i), sv_a, vecs[i].sv);
            chk($sformatf("v%0d_sel_index", i), sidx_a, vecs[i].sidx);
            chk($sformatf("v%0d_cx", i), cx_a, vecs[i].cx);
        end
        // Non-wrapping instance saw the same left pulse at index 0.
        chk("nowrap_left_idx", idx_b, 0);
        chk("nowrap_left_moving", mov_b, 0);

        // Wrap-around climb 65 -> 490, final step clamped to 1 px.
        for (n = 1; n <= 110; n++) begin
            @(negedge clk);
            l = 1'b0;
            cyc();
            exp_cx = (65 + 4 * n > 490) ? 490 : 65 + 4 * n;
            chk($sformatf("wrap_cx_%0d", n), cx_a, exp_cx);
            chk($sformatf("wrap_moving_%0d", n), mov_a, (n < 107) ? 1 : 0);
            chk($sformatf("nowrap_moving_%0d", n), mov_b, 0);
            chk($sformatf("nowrap_cx_%0d", n), cx_b, 65);
        end

        // Right from slot 0: default steps every cycle, divided instance every 3rd.
        do_reset();
        @(negedge clk);
        r = 1'b1;
        cyc();
        chk("right_idx", idx_a, 1);
        chk("right_moving", mov_a, 1);
        chk("right_cx0", cx_a, 65);
        chk("right_idx_div", idx_c, 1);
        chk("right_idx_nowrap", idx_b, 1);
        for (n = 1; n <= 110; n++) begin
            @(negedge clk);
            r = 1'b0;
            cyc();
            chk($sformatf("r_cx_%0d", n), cx_a, (n <= 35) ? 65 + 4 * n : 205);
            chk($sformatf("r_mov_%0d", n), mov_a, (n < 35) ? 1 : 0);
            chk($sformatf("r_cx_div_%0d", n), cx_c, (n <= 105) ? 65 + 4 * (n / 3) : 205);
            chk($sformatf("r_mov_div_%0d", n), mov_c, (n < 105) ? 1 : 0);
        end

        // Move to slot 2, then select with a delayed ack.
        @(negedge clk);
        r = 1'b1;
        cyc();
        found = 1'b0;
        for (n = 0; n < 400; n++) begin
            @(negedge clk);
            r = 1'b0;
            cyc();
            if (!mov_a && !mov_b && !mov_c) begin
                found = 1'b1;
                break;
            end
        end
        chk("move2_settled", found, 1);
        chk("move2_cx", cx_a, 335);
        chk("move2_idx", idx_a, 2);
        @(negedge clk);
        s = 1'b1;
        cyc();
        chk("sel_valid", sv_a, 1);
        chk("sel_index", sidx_a, 2);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            s = 1'b0;
            l = (k % 2 == 0) ? 1'b1 : 1'b0;
            cyc();
            chk($sformatf("sel_hold_valid_%0d", k), sv_a, 1);
            chk($sformatf("sel_hold_index_%0d", k), sidx_a, 2);
            chk($sformatf("sel_hold_idx_%0d", k), idx_a, 2);
            chk($sformatf("sel_hold_moving_%0d", k), mov_a, 0);
        end
        @(negedge clk);
        l = 1'b0;
        ack = 1'b1;
        cyc();
        chk("ack_valid", sv_a, 0);
        chk("ack_idx", idx_a, 2);
        chk("ack_moving", mov_a, 0);
        @(negedge clk);
        ack = 1'b0;

        // Right held through reset release produces no command.
        @(negedge clk);
        r = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("held_idx_%0d", k), idx_a, 0);
            chk($sformatf("held_moving_%0d", k), mov_a, 0);
            chk($sformatf("held_cx_%0d", k), cx_a, 65);
        end
        @(negedge clk);
        r = 1'b0;
        cyc();

        // Asynchronous reset mid-move at cx=121.
        @(negedge clk);
        r = 1'b1;
        cyc();
        found = 1'b0;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            r = 1'b0;
            cyc();
            if (cx_a == 16'd121) begin
                found = 1'b1;
                break;
            end
        end
        chk("midmove_reached_121", found, 1);
        chk("midmove_moving", mov_a, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_cx", cx_a, 65);
        chk("async_idx", idx_a, 0);
        chk("async_moving", mov_a, 0);
        chk("async_cx_div", cx_c, 65);
        chk("async_moving_div", mov_c, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("post_reset_idx", idx_a, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/menu_cursor.md
MENU_CURSOR -- requirements
Module: menu_cursor

Interface
REQ-001 SHALL have parameter N_ITEMS, default 4, number of menu slots (2..16).
REQ-002 SHALL have parameter POS_X, default {16'd490,16'd335,16'd205,16'd65}, packed N_ITEMS*16 slot x-coordinates, slot 0 in LSBs.
REQ-003 SHALL have parameter MY, default 430, constant cursor y-coordinate.
REQ-004 SHALL have parameter R, default 10, constant cursor radius.
REQ-005 SHALL have parameter STEP, default 4, pixels moved per animation tick (>=1).
REQ-006 SHALL have parameter TICK_DIV, default 1, clock cycles per animation tick (>=1).
REQ-007 SHALL have parameter WRAP, default 1; 1 = index wraps at ends, 0 = index saturates.
REQ-008 SHALL have localparam IW = clog2(N_ITEMS), minimum 1.
REQ-009 i_clk  in  1  sole clock, rising edge.
REQ-010 i_rst_n  in  1  asynchronous, active-low reset.
REQ-011 i_enable  in  1  high = accept new left/right/select commands.
REQ-012 i_left  in  1  level button, synchronous to i_clk, already debounced.
REQ-013 i_right  in  1  level button, same rules as i_left.
REQ-014 i_select  in  1  level button, same rules as i_left.
REQ-015 i_sel_ack  in  1  consumer acknowledge of selection.
REQ-016 o_cx  out  16  current (animated) cursor x.
REQ-017 o_cy  out  16  constant MY.
REQ-018 o_cr  out  16  constant R.
REQ-019 o_index  out  IW  committed (target) slot index.
REQ-020 o_moving  out  1  high while in MOVE.
REQ-021 o_sel_valid  out  1  selection pending.
REQ-022 o_sel_index  out  IW  slot selected; meaningful while o_sel_valid.

Function
REQ-023 Each button SHALL be rising-edge detected against a 1-cycle-delayed copy; a command is the cycle where the input is 1 and the delayed copy is 0.
REQ-024 FSM states SHALL be IDLE, MOVE, SELECT; transitions take effect on the clock edge after the command cycle (1-cycle latency).
REQ-025 IDLE + i_enable + left edge only -> MOVE, o_index <= index-1 (WRAP=1: 0 -> N_ITEMS-1; WRAP=0: 0 stays 0, remain IDLE).
REQ-026 IDLE + i_enable + right edge only -> MOVE, o_index <= index+1 (WRAP=1: N_ITEMS-1 -> 0; WRAP=0: saturate, remain IDLE).
REQ-027 Simultaneous left and right edges SHALL be ignored (no state or index change).
REQ-028 IDLE + i_enable + select edge -> SELECT, o_sel_valid <= 1, o_sel_index <= o_index; select has priority over left/right in the same cycle.
REQ-029 In MOVE, a tick counter SHALL run 0..TICK_DIV-1, restarting at 0 on MOVE entry; on count TICK_DIV-1, o_cx moves STEP toward POS_X[o_index], clamped so it never overshoots.
REQ-030 MOVE -> IDLE on the edge where o_cx becomes equal to the target; o_moving deasserts with that edge.
REQ-031 Left/right/select edges during MOVE or SELECT SHALL be discarded, not queued.
REQ-032 In SELECT, o_sel_valid and o_sel_index SHALL hold stable until a cycle with i_sel_ack=1; the next edge returns to IDLE with o_sel_valid=0.
REQ-033 i_sel_ack outside SELECT SHALL have no effect.
REQ-034 i_enable low SHALL block new commands only; an in-progress MOVE completes and a pending selection stays valid.
REQ-035 Movement arithmetic SHALL be unsigned 16-bit; the direction is determined by comparing o_cx against the target, independent of wrap direction.
REQ-036 o_cy and o_cr SHALL be combinational constants.

Reset
REQ-037 While i_rst_n=0 (asynchronously): state IDLE, o_index=0, o_cx=POS_X[0], o_moving=0, o_sel_valid=0, o_sel_index=0, tick counter 0.
REQ-038 Edge-detector delay registers SHALL reset to 1, so a button held through reset release produces no command.
REQ-039 Reset asserted mid-MOVE or mid-SELECT SHALL abort immediately to the REQ-037 values; no selection survives reset.

Verification
REQ-040 Defaults: reset, one right pulse -> o_index=1 next cycle; o_cx 65->69->...->205 over 35 cycles; o_moving falls on the cycle o_cx=205.
REQ-041 WRAP=1: from index 0, left pulse -> o_index=3, o_cx climbs 65->490 in 107 cycles (last step clamped, 1 px). WRAP=0: same stimulus -> o_index stays 0, o_moving stays 0.
REQ-042 TICK_DIV=3, STEP=4: right from 0 -> o_cx changes only every 3rd cycle; 205 reached after 105 cycles in MOVE.
REQ-043 Select at index 2 with ack held low 10 cycles -> o_sel_valid=1, o_sel_index=2 stable; left pulses in that window ignored; ack -> valid=0 next cycle, o_index still 2.
REQ-044 Left and right rising in the same cycle -> no change; i_right held high across reset release -> no move; i_enable=0 with right pulse -> no move.
REQ-045 Reset asserted mid-MOVE at o_cx=121 -> o_cx=65, o_index=0, o_moving=0 without waiting for a clock edge.
